// File: rtl/sgdmac_wr_slave.sv
// AXI3 write slave for the scatter-gather DMA controller: accepts one burst at a
// time and turns each accepted W beat into a single-cycle write on a simple memory port.
module sgdmac_wr_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,

    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,

    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,

    output logic        mem_wren_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;
    localparam logic [1:0] RESP_DEC   = 2'b11;

    state_t      state;
    state_t      state_next;
    logic        awready_q;

    logic [3:0]  id_q;
    logic [29:0] addr_q;
    logic [3:0]  cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        dec_err_q;
    logic        slv_err_q;

    logic        aw_hs;
    logic        w_beat;
    logic        last_beat;
    logic [31:0] cur_addr;
    logic [31:0] offset;
    logic        in_range;
    logic        burst_bad;
    logic        proto_bad;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^awaddr_i[1:0];

    assign aw_hs     = (state == IDLE) && awready_q && awvalid_i;
    assign w_beat    = (state == DATA) && wvalid_i && mem_ready_i;
    assign last_beat = (cnt_q == 4'd0);
    assign cur_addr  = {addr_q, 2'b00};
    // Unsigned wrap makes addresses below the base look huge, so one compare covers both bounds.
    assign offset    = cur_addr - ADDR_BASE;
    assign in_range  = (offset < ADDR_SIZE);
    assign burst_bad = (size_q != SIZE_WORD) || burst_q[1];
    assign proto_bad = (wlast_i != last_beat) || (wid_i != id_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            awready_q <= 1'b0;
        end else begin
            state     <= state_next;
            awready_q <= (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (aw_hs) state_next = DATA;
            DATA: if (w_beat && last_beat) state_next = RESP;
            RESP: if (bready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= 4'd0;
            addr_q    <= 30'd0;
            cnt_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            dec_err_q <= 1'b0;
            slv_err_q <= 1'b0;
        end else if (aw_hs) begin
            id_q      <= awid_i;
            addr_q    <= awaddr_i[31:2];
            cnt_q     <= awlen_i;
            size_q    <= awsize_i;
            burst_q   <= awburst_i;
            dec_err_q <= 1'b0;
            slv_err_q <= 1'b0;
        end else if (w_beat) begin
            cnt_q <= cnt_q - 4'd1;
            if (burst_q == BURST_INCR) begin
                addr_q <= addr_q + 30'd1;
            end
            if (!in_range) begin
                dec_err_q <= 1'b1;
            end
            if (proto_bad) begin
                slv_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        awready_o   = awready_q;
        wready_o    = (state == DATA) && mem_ready_i;
        bvalid_o    = (state == RESP);
        bid_o       = 4'd0;
        bresp_o     = RESP_OKAY;
        mem_wren_o  = w_beat && in_range && !burst_bad;
        mem_addr_o  = offset;
        mem_wdata_o = wdata_i;
        mem_wstrb_o = wstrb_i;
        if (state == RESP) begin
            bid_o = id_q;
            if (dec_err_q) begin
                bresp_o = RESP_DEC;
            end else if (slv_err_q || burst_bad) begin
                bresp_o = RESP_SLV;
            end
        end
    end

endmodule

// File: tb/tb_sgdmac_wr_slave.sv
// Directed and randomized bursts against sgdmac_wr_slave, checked against a
// burst-level model of expected memory writes and write response.
module tb_sgdmac_wr_slave;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready_o;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready = 1'b0;
    logic        mem_wren_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] gotAddr[$];
    logic [31:0] gotData[$];
    logic [3:0]  gotStrb[$];

    sgdmac_wr_slave #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut (
        .clk(clk), .rst(rst),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready_o),
        .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
        .mem_wren_o(mem_wren_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: every strobed write lands in the capture queues.
    always @(negedge clk) begin
        if (!rst && mem_wren_o) begin
            gotAddr.push_back(mem_addr_o);
            gotData.push_back(mem_wdata_o);
            gotStrb.push_back(mem_wstrb_o);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_awready"}, 32'(awready_o), 32'd0);
        checkOutput({tag, "_wready"}, 32'(wready_o), 32'd0);
        checkOutput({tag, "_bvalid"}, 32'(bvalid_o), 32'd0);
        checkOutput({tag, "_wren"}, 32'(mem_wren_o), 32'd0);
        checkOutput({tag, "_bid"}, 32'(bid_o), 32'd0);
        checkOutput({tag, "_bresp"}, 32'(bresp_o), 32'd0);
    endtask

    task automatic sendAw(input string name, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        bit seen = 0;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (awready_o) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput({name, "_aw_accept"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    // One full burst: model the expected writes/response, drive AW, W and B, then compare.
    task automatic applyStimulus(input string name, input logic [3:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                                 input int lastIdx, input int widErrBeat, input int readyMode,
                                 input int breadyDelay, input bit earlyW);
        logic [31:0] data[16];
        logic [3:0]  strb[16];
        logic [31:0] expAddr[$];
        logic [31:0] expData[$];
        logic [3:0]  expStrb[$];
        logic [31:0] beatAddr;
        logic [31:0] off;
        logic [1:0]  expResp;
        bit typeBad;
        bit decErr = 0;
        bit slvErr = 0;
        bit seen = 0;
        int beat = 0;
        int cycles = 0;

        typeBad = (size != 3'd2) || (burst == 2'b10) || (burst == 2'b11);
        for (int i = 0; i <= int'(len); i++) begin
            data[i] = $urandom;
            strb[i] = 4'($urandom_range(0, 15));
            beatAddr = {addr[31:2], 2'b00};
            if (burst == 2'b01) beatAddr = beatAddr + 32'(4 * i);
            off = beatAddr - BASE;
            if (off >= SIZE) decErr = 1;
            if ((i == lastIdx) != (i == int'(len))) slvErr = 1;
            if (i == widErrBeat) slvErr = 1;
            if (off < SIZE && !typeBad) begin
                expAddr.push_back(off);
                expData.push_back(data[i]);
                expStrb.push_back(strb[i]);
            end
        end
        expResp = decErr ? 2'b11 : ((slvErr || typeBad) ? 2'b10 : 2'b00);

        gotAddr.delete();
        gotData.delete();
        gotStrb.delete();

        if (earlyW) begin
            @(posedge clk); #1;
            wvalid = 1'b1; wdata = data[0]; wstrb = strb[0]; wid = id; wlast = (lastIdx == 0);
            mem_ready = 1'b1;
            repeat (2) begin
                @(negedge clk);
                checkOutput({name, "_early_wready"}, 32'(wready_o), 32'd0);
            end
        end

        sendAw(name, id, addr, len, size, burst);

        for (int c = 0; c < 400 && beat <= int'(len); c++) begin
            case (readyMode)
                0: mem_ready = 1'b1;
                1: mem_ready = (c % 2 == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            wvalid = 1'b1;
            wdata = data[beat];
            wstrb = strb[beat];
            wlast = (beat == lastIdx);
            wid = (beat == widErrBeat) ? (id ^ 4'h5) : id;
            @(negedge clk);
            cycles++;
            if (c == 0) checkOutput({name, "_awready_in_data"}, 32'(awready_o), 32'd0);
            if (readyMode == 1) checkOutput({name, "_wready_track"}, 32'(wready_o), 32'(mem_ready));
            if (wready_o) beat++;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        checkOutput({name, "_beats"}, 32'(beat), 32'(int'(len) + 1));
        if (readyMode == 0) checkOutput({name, "_cycles"}, 32'(cycles), 32'(int'(len) + 1));

        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bvalid_o) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput({name, "_bvalid_seen"}, 32'(seen), 32'd1);
        checkOutput({name, "_bid"}, 32'(bid_o), 32'(id));
        checkOutput({name, "_bresp"}, 32'(bresp_o), 32'(expResp));
        for (int d = 0; d < breadyDelay; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput({name, "_hold_bvalid"}, 32'(bvalid_o), 32'd1);
            checkOutput({name, "_hold_bid"}, 32'(bid_o), 32'(id));
            checkOutput({name, "_hold_bresp"}, 32'(bresp_o), 32'(expResp));
            checkOutput({name, "_hold_awready"}, 32'(awready_o), 32'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        checkOutput({name, "_hs_bvalid"}, 32'(bvalid_o), 32'd1);
        checkOutput({name, "_hs_awready"}, 32'(awready_o), 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        checkOutput({name, "_post_awready"}, 32'(awready_o), 32'd1);
        checkOutput({name, "_post_bvalid"}, 32'(bvalid_o), 32'd0);

        checkOutput({name, "_write_count"}, 32'(gotAddr.size()), 32'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
            checkOutput({name, "_waddr"}, gotAddr[i], expAddr[i]);
            checkOutput({name, "_wdata"}, gotData[i], expData[i]);
            checkOutput({name, "_wstrb"}, 32'(gotStrb[i]), 32'(expStrb[i]));
        end
    endtask

    // Abandon a 16-beat burst with reset while its fifth beat is on the bus.
    task automatic doResetTest();
        logic [31:0] data[16];
        bit sawB = 0;
        for (int i = 0; i < 16; i++) data[i] = $urandom;
        gotAddr.delete();
        gotData.delete();
        gotStrb.delete();
        sendAw("rst_mid", 4'd9, BASE + 32'h200, 4'd15, 3'd2, 2'b01);
        mem_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wvalid = 1'b1; wdata = data[b]; wstrb = 4'hF; wid = 4'd9; wlast = 1'b0;
            @(negedge clk);
            checkOutput("rst_mid_wready", 32'(wready_o), 32'd1);
            @(posedge clk); #1;
        end
        wdata = data[4];
        #1;
        rst = 1'b1;
        #1;
        checkAllLow("rst_mid_async");
        wvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bvalid_o) sawB = 1;
        end
        checkOutput("rst_mid_no_bresp", 32'(sawB), 32'd0);
        checkOutput("rst_mid_writes", 32'(gotAddr.size()), 32'd4);
        for (int i = 0; i < 4 && i < gotAddr.size(); i++) begin
            checkOutput("rst_mid_waddr", gotAddr[i], 32'h200 + 32'(4 * i));
            checkOutput("rst_mid_wdata", gotData[i], data[i]);
        end
    endtask

    initial begin
        $display("[TB] start");
        wvalid = 1'b1;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        checkAllLow("reset");
        wvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_awready_before_edge", 32'(awready_o), 32'd0);
        @(posedge clk); #1;
        checkOutput("reset_awready_after_edge", 32'(awready_o), 32'd1);

        applyStimulus("incr16", 4'd3, BASE + 32'h100, 4'd15, 3'd2, 2'b01, 15, -1, 0, 0, 0);
        applyStimulus("incr16_toggle", 4'd3, BASE + 32'h100, 4'd15, 3'd2, 2'b01, 15, -1, 1, 0, 1);
        applyStimulus("early_wlast", 4'd6, BASE + 32'h40, 4'd3, 3'd2, 2'b01, 2, -1, 0, 0, 0);
        applyStimulus("cross_top", 4'd1, BASE + 32'hFF8, 4'd3, 3'd2, 2'b01, 3, -1, 0, 0, 0);
        applyStimulus("bad_size", 4'd2, BASE + 32'h80, 4'd3, 3'd1, 2'b01, 3, -1, 0, 0, 0);
        applyStimulus("bready_wait", 4'd12, BASE + 32'h300, 4'd2, 3'd2, 2'b01, 2, -1, 0, 5, 0);
        applyStimulus("wid_err", 4'd7, BASE + 32'h500, 4'd4, 3'd2, 2'b01, 4, 2, 0, 0, 0);
        applyStimulus("fixed", 4'd4, BASE + 32'h7F0, 4'd5, 3'd2, 2'b00, 5, -1, 2, 1, 0);
        applyStimulus("below_base", 4'd5, BASE - 32'h10, 4'd1, 3'd2, 2'b01, 1, -1, 0, 0, 0);
        applyStimulus("wrap_burst", 4'd8, BASE + 32'h20, 4'd3, 3'd2, 2'b10, 3, -1, 0, 0, 0);

        for (int n = 0; n < 8; n++) begin
            applyStimulus("random", 4'($urandom_range(0, 15)), BASE + $urandom_range(0, 32'hFFF),
                          4'($urandom_range(0, 15)), 3'd2, 2'($urandom_range(0, 1)),
                          -2, -1, 2, int'($urandom_range(0, 3)), 0);
        end

        doResetTest();
        applyStimulus("after_reset", 4'd10, BASE + 32'hC00, 4'd7, 3'd2, 2'b01, 7, -1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
